fetch_queue_mc: RTL and testbench

- Parametrised multi-port instruction fetch queue. Sits between the I-cache fetch stage and the decoders.
- Accepts up to WRITE_PORT slots per cycle with an arbitrary per-slot valid mask. Sparse masks are compacted in-order, lowest slot first.
- Presents up to READ_PORT oldest entries per cycle; the consumer pops any count 0..READ_PORT.
- New relative to the previous queue: arbitrary (non-contiguous) write masks, occupancy/almost-full outputs, and clipping of over-reads.

---
 rtl/fetch_queue_pkg.sv | 22 ++
 rtl/valid_compact.sv | 29 ++
 rtl/fetch_queue_mc.sv | 115 +++++++++++
 tb/tb_fetch_queue_mc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the fetch queue and other frontend blocks.
package fetch_queue_pkg;

    localparam int unsigned SLOT_WIDTH = 64;

    typedef logic [SLOT_WIDTH-1:0] slot_t;

    // Pointer carries one extra wrap bit above the entry index.
    function automatic int unsigned ptr_width(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [3:0] popcount(logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/valid_compact.sv
// Compacts a sparse valid mask into an ordered list of set slot indices, lowest first.
module valid_compact
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WRITE_PORT = 4,
    parameter int unsigned IDX_W      = (WRITE_PORT > 1) ? $clog2(WRITE_PORT) : 1
) (
    input  logic [WRITE_PORT-1:0]            mask_i,
    output logic [WRITE_PORT-1:0][IDX_W-1:0] slot_idx_o,
    output logic [IDX_W:0]                   count_o
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [IDX_W:0] k;

    always_comb begin
        slot_idx_o = '0;
        k          = '0;
        for (int i = 0; i < WRITE_PORT; i++) begin
            if (mask_i[i]) begin
                slot_idx_o[k[IDX_W-1:0]] = IDX_W'(i);
                k                        = k + 1'b1;
            end
        end
        count_o = CNT_W'(popcount(8'(mask_i)));
    end

endmodule

// File: rtl/fetch_queue_mc.sv
// Multi-port instruction fetch queue: sparse in-order writes, up to READ_PORT oldest reads.
module fetch_queue_mc
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WRITE_PORT = 4,
    parameter int unsigned READ_PORT  = 2,
    parameter int unsigned AF_THRESH  = DEPTH - 2 * WRITE_PORT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic [WRITE_PORT-1:0]            write_valid_i,
    input  logic [WRITE_PORT*DATA_WIDTH-1:0] write_data_i,
    output logic                             write_ready_o,
    output logic [READ_PORT-1:0]             read_valid_o,
    output logic [READ_PORT*DATA_WIDTH-1:0]  read_data_o,
    input  logic [$clog2(READ_PORT+1)-1:0]   read_num_i,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             almost_full_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned IDX_W = (WRITE_PORT > 1) ? $clog2(WRITE_PORT) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] AF_LVL   = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] WR_LIMIT = PTR_W'(DEPTH - WRITE_PORT);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] occ, nr, nw, rn_ext;
    logic             do_write;

    logic [WRITE_PORT-1:0][IDX_W-1:0] slot_idx;
    logic [IDX_W:0]                   valid_cnt;

    logic [WRITE_PORT-1:0][PTR_W-1:0]      wptr;
    logic [WRITE_PORT-1:0]                 wen;
    logic [WRITE_PORT-1:0][DATA_WIDTH-1:0] wdata;
    logic [READ_PORT-1:0][PTR_W-1:0]       rptr;

    valid_compact #(
        .WRITE_PORT (WRITE_PORT),
        .IDX_W      (IDX_W)
    ) u_compact (
        .mask_i     (write_valid_i),
        .slot_idx_o (slot_idx),
        .count_o    (valid_cnt)
    );

    // Occupancy and readiness come from registered pointers only.
    assign occ           = tail_q - head_q;
    assign write_ready_o = (occ <= WR_LIMIT);
    assign almost_full_o = (occ >= AF_LVL);
    assign count_o       = CNT_W'(occ);

    assign do_write = write_ready_o && !flush_i;
    assign nw       = do_write ? PTR_W'(valid_cnt) : '0;
    assign rn_ext   = PTR_W'(read_num_i);
    assign nr       = (rn_ext > occ) ? occ : rn_ext;

    always_comb begin
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + nr;
            tail_d = tail_q + nw;
        end
    end

    always_comb begin
        for (int k = 0; k < WRITE_PORT; k++) begin
            wptr[k]  = tail_q + PTR_W'(k);
            wen[k]   = (PTR_W'(k) < nw);
            wdata[k] = write_data_i[int'(slot_idx[k])*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        for (int j = 0; j < READ_PORT; j++) begin
            rptr[j]                                  = head_q + PTR_W'(j);
            read_valid_o[j]                          = (occ > PTR_W'(j));
            read_data_o[j*DATA_WIDTH +: DATA_WIDTH]  = mem[rptr[j][AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < WRITE_PORT; k++) begin
            if (wen[k]) begin
                mem[wptr[k][AW-1:0]] <= wdata[k];
            end
        end
    end

    // Over-reads are clipped in hardware; flag them so the consumer bug is visible.
    a_no_overread : assert property (@(posedge clk) disable iff (rst)
        int'(read_num_i) <= int'(popcount(8'(read_valid_o))))
    else $warning("over-read: read_num_i=%0d exceeds valid entries", read_num_i);

endmodule

// File: tb/tb_fetch_queue_mc.sv
// Directed bench for fetch_queue_mc with hand-computed expectations.
module tb_fetch_queue_mc;

    localparam int DW = 64;
    localparam int WP = 4;
    localparam int RP = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic [WP-1:0]    write_valid_i;
    logic [WP*DW-1:0] write_data_i;
    logic             write_ready_o;
    logic [RP-1:0]    read_valid_o;
    logic [RP*DW-1:0] read_data_o;
    logic [1:0]       read_num_i;
    logic [4:0]       count_o;
    logic             almost_full_o;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_queue_mc dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .write_valid_i (write_valid_i),
        .write_data_i  (write_data_i),
        .write_ready_o (write_ready_o),
        .read_valid_o  (read_valid_o),
        .read_data_o   (read_data_o),
        .read_num_i    (read_num_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample #1 after the edge.
    task automatic cycle(input logic fl, input logic [3:0] mask, input logic [1:0] rn,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [63:0] d3);
        flush_i       = fl;
        write_valid_i = mask;
        read_num_i    = rn;
        write_data_i  = {d3, d2, d1, d0};
        @(posedge clk);
        #1;
        flush_i       = 1'b0;
        write_valid_i = '0;
        read_num_i    = '0;
        write_data_i  = '0;
    endtask

    function automatic logic [63:0] rd(input int j);
        return read_data_o[j*DW +: DW];
    endfunction

    initial begin
        rst           = 1'b1;
        flush_i       = 1'b0;
        write_valid_i = '0;
        write_data_i  = '0;
        read_num_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_rvalid", 64'(read_valid_o), 64'd0);
        check("rst_wready", 64'(write_ready_o), 64'd1);
        check("rst_afull", 64'(almost_full_o), 64'd0);
        rst = 1'b0;

        // Sparse mask compaction.
        cycle(1'b0, 4'b1010, 2'd0, 64'hA, 64'hB, 64'hC, 64'hD);
        check("sparse_count", 64'(count_o), 64'd2);
        check("sparse_rvalid", 64'(read_valid_o), 64'b11);
        check("sparse_port0", rd(0), 64'hB);
        check("sparse_port1", rd(1), 64'hD);
        cycle(1'b0, 4'b0000, 2'd2, 0, 0, 0, 0);
        check("drain_count", 64'(count_o), 64'd0);

        // Fill to 12, then 16.
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 4'b1111, 2'd0, 64'h100 + 64'(4*n), 64'h101 + 64'(4*n),
                  64'h102 + 64'(4*n), 64'h103 + 64'(4*n));
        end
        check("fill12_count", 64'(count_o), 64'd12);
        check("fill12_wready", 64'(write_ready_o), 64'd1);
        check("fill12_afull", 64'(almost_full_o), 64'd1);
        cycle(1'b0, 4'b1111, 2'd0, 64'h10C, 64'h10D, 64'h10E, 64'h10F);
        check("full_count", 64'(count_o), 64'd16);
        check("full_wready", 64'(write_ready_o), 64'd0);
        check("full_afull", 64'(almost_full_o), 64'd1);
        cycle(1'b0, 4'b1111, 2'd0, 64'h1, 64'h2, 64'h3, 64'h4);
        check("full_drop_count", 64'(count_o), 64'd16);
        check("full_oldest", rd(0), 64'h100);

        // Walk head to 14 for the wrap test.
        cycle(1'b1, 4'b0000, 2'd0, 0, 0, 0, 0);
        check("flush1_count", 64'(count_o), 64'd0);
        cycle(1'b0, 4'b0011, 2'd0, 64'h200, 64'h201, 0, 0);
        for (int n = 0; n < 6; n++) begin
            cycle(1'b0, 4'b0011, 2'd2, 64'h210 + 64'(n), 64'h220 + 64'(n), 0, 0);
        end
        check("walk_count", 64'(count_o), 64'd2);
        check("walk_port0", rd(0), 64'h215);
        cycle(1'b0, 4'b0000, 2'd2, 0, 0, 0, 0);
        check("walk_empty", 64'(count_o), 64'd0);

        cycle(1'b0, 4'b1111, 2'd0, 64'hE0, 64'hE1, 64'hE2, 64'hE3);
        check("wrap_count", 64'(count_o), 64'd4);
        check("wrap_p0_e0", rd(0), 64'hE0);
        check("wrap_p1_e1", rd(1), 64'hE1);
        cycle(1'b0, 4'b0000, 2'd2, 0, 0, 0, 0);
        check("wrap_p0_e2", rd(0), 64'hE2);
        check("wrap_p1_e3", rd(1), 64'hE3);
        cycle(1'b0, 4'b0000, 2'd2, 0, 0, 0, 0);
        check("wrap_empty", 64'(count_o), 64'd0);

        // Concurrent write 3 / pop 2 at count 5.
        cycle(1'b0, 4'b1111, 2'd0, 64'hF0, 64'hF1, 64'hF2, 64'hF3);
        cycle(1'b0, 4'b0001, 2'd0, 64'hF4, 0, 0, 0);
        check("pre_rw_count", 64'(count_o), 64'd5);
        cycle(1'b0, 4'b0111, 2'd2, 64'h60, 64'h61, 64'h62, 0);
        check("rw_count", 64'(count_o), 64'd6);
        check("rw_port0", rd(0), 64'hF2);
        check("rw_port1", rd(1), 64'hF3);

        // Drain to one, then over-read.
        cycle(1'b0, 4'b0000, 2'd2, 0, 0, 0, 0);
        cycle(1'b0, 4'b0000, 2'd2, 0, 0, 0, 0);
        cycle(1'b0, 4'b0000, 2'd1, 0, 0, 0, 0);
        check("one_count", 64'(count_o), 64'd1);
        check("one_rvalid", 64'(read_valid_o), 64'b01);
        check("one_port0", rd(0), 64'h62);
        cycle(1'b0, 4'b0000, 2'd2, 0, 0, 0, 0);
        check("overread_count", 64'(count_o), 64'd0);
        check("overread_rvalid", 64'(read_valid_o), 64'd0);
        check("overread_wready", 64'(write_ready_o), 64'd1);

        // Flush beats write and pop at count 7.
        cycle(1'b0, 4'b1111, 2'd0, 64'h70, 64'h71, 64'h72, 64'h73);
        cycle(1'b0, 4'b1110, 2'd0, 64'h0, 64'h74, 64'h75, 64'h76);
        check("pre_flush_count", 64'(count_o), 64'd7);
        check("pre_flush_port0", rd(0), 64'h70);
        cycle(1'b1, 4'b1111, 2'd1, 64'h80, 64'h81, 64'h82, 64'h83);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_rvalid", 64'(read_valid_o), 64'd0);
        cycle(1'b0, 4'b0100, 2'd0, 0, 0, 64'h99, 0);
        check("post_flush_count", 64'(count_o), 64'd1);
        check("post_flush_port0", rd(0), 64'h99);
        check("post_flush_entry0", dut.mem[0], 64'h99);

        // Asynchronous reset mid-operation.
        cycle(1'b0, 4'b0011, 2'd0, 64'h5, 64'h6, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", 64'(count_o), 64'd0);
        check("async_rst_rvalid", 64'(read_valid_o), 64'd0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
